// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector serializer.
// Holds the two-state machine encoding and the index-width formula.
// Ports: none (package).
package vec_pkg;

  typedef enum logic {IDLE, SEND} vs_state_t;

  // Index width for an n-element vector; a single element still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_serializer.sv
// Purpose: splits one N-element vector into N beats, index 0 first, each
//   carrying a running prefix sum that wraps at WIDTH bits.
// Latency: first beat one cycle after the vector is accepted; one beat per cycle.
// Backpressure: out_ready low freezes every output and register; a new vector
//   is accepted while idle or together with the final beat, so there is no bubble.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      vector handshake, in_data[i] = element i
//   out_valid/out_ready    beat handshake
//   out_data/out_idx       current element and its index
//   out_last               final beat of the vector
//   out_sum                wrapped sum of elements 0..out_idx
module vec_serializer
  import vec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int IW   = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data [N-1:0],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic [WIDTH-1:0] out_sum
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  vs_state_t        state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] vec_buf [N-1:0];

  logic accept;
  logic xfer;

  always_comb begin
    out_valid = (state == SEND);
    out_idx   = idx;
    out_data  = vec_buf[idx];
    // acc holds the sum of the elements already sent; add the one on show.
    out_sum   = acc + vec_buf[idx];
    out_last  = out_valid && (idx == LAST_IDX);
    // Taking the final beat frees the buffer in the same cycle, so a waiting
    // vector can be loaded on that edge.
    in_ready  = (state == IDLE) || (out_last && out_ready);
    accept    = in_valid && in_ready;
    xfer      = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
    end else if (accept) begin
      vec_buf <= in_data;
      idx     <= '0;
      acc     <= '0;
      state   <= SEND;
    end else if (xfer) begin
      if (out_last) begin
        state <= IDLE;
      end else begin
        idx <= idx + IW'(1);
        acc <= out_sum;
      end
    end
  end

endmodule

// File: tb/tb_vec_serializer.sv
// Bench for vec_serializer: directed table vectors, hand-written stall /
// back-to-back / reset sequences, small-parameter instances and random traffic.
module tb_vec_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: WIDTH=8, N=4
  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [7:0] a_in_data [3:0];
  logic       a_out_valid;
  logic       a_out_ready = 1'b1;
  logic [7:0] a_out_data;
  logic [1:0] a_out_idx;
  logic       a_out_last;
  logic [7:0] a_out_sum;

  // WIDTH=4, N=2
  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [3:0] b_in_data [1:0];
  logic       b_out_valid;
  logic       b_out_ready = 1'b1;
  logic [3:0] b_out_data;
  logic       b_out_idx;
  logic       b_out_last;
  logic [3:0] b_out_sum;

  // WIDTH=8, N=1
  logic       c_in_valid = 1'b0;
  logic       c_in_ready;
  logic [7:0] c_in_data [0:0];
  logic       c_out_valid;
  logic       c_out_ready = 1'b1;
  logic [7:0] c_out_data;
  logic       c_out_idx;
  logic       c_out_last;
  logic [7:0] c_out_sum;

  vec_serializer #(.WIDTH(8), .N(4)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_idx(a_out_idx), .out_last(a_out_last), .out_sum(a_out_sum)
  );

  vec_serializer #(.WIDTH(4), .N(2)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .out_last(b_out_last), .out_sum(b_out_sum)
  );

  vec_serializer #(.WIDTH(8), .N(1)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_idx(c_out_idx), .out_last(c_out_last), .out_sum(c_out_sum)
  );

  typedef struct packed {
    logic [3:0][7:0] v;  // elements
    logic [3:0][7:0] s;  // expected prefix sums
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl [0:4];

  function automatic vec_t mk(input int v0, input int v1, input int v2, input int v3,
                              input int s0, input int s1, input int s2, input int s3);
    vec_t t;
    t.v = {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
    t.s = {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int d, input int k, input int s);
    chk({tag, "_valid"}, {31'd0, a_out_valid}, 32'd1);
    chk({tag, "_data"},  {24'd0, a_out_data},  d);
    chk({tag, "_idx"},   {30'd0, a_out_idx},   k);
    chk({tag, "_last"},  {31'd0, a_out_last},  (k == 3) ? 32'd1 : 32'd0);
    chk({tag, "_sum"},   {24'd0, a_out_sum},   s);
  endtask

  task automatic load_a(input vec_t t);
    for (int i = 0; i < 4; i++) a_in_data[i] = t.v[i];
  endtask

  // Present a vector while idle, then check its four beats with out_ready high.
  task automatic run_table(input string tag, input vec_t t);
    a_in_valid = 1'b1;
    load_a(t);
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_beat(tag, t.v[k], k, t.s[k]);
      @(negedge clk);
    end
    chk({tag, "_idle"}, {31'd0, a_out_valid}, 32'd0);
  endtask

  initial begin
    int v [4];
    int k;
    int budget;
    int run;

    tbl[0] = mk(10, 20, 30, 40,    10, 30, 60, 100);
    tbl[1] = mk(200, 150, 100, 50, 200, 94, 194, 244);
    tbl[2] = mk(1, 2, 3, 4,        1, 3, 6, 10);
    tbl[3] = mk(5, 6, 7, 8,        5, 11, 18, 26);
    tbl[4] = mk(9, 9, 9, 9,        9, 18, 27, 36);

    for (int i = 0; i < 4; i++) a_in_data[i] = 8'd0;
    for (int i = 0; i < 2; i++) b_in_data[i] = 4'd0;
    c_in_data[0] = 8'd0;

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_a_out_last",  {31'd0, a_out_last},  32'd0);
    chk("rst_a_in_ready",  {31'd0, a_in_ready},  32'd1);
    chk("rst_b_in_ready",  {31'd0, b_in_ready},  32'd1);
    chk("rst_c_out_valid", {31'd0, c_out_valid}, 32'd0);

    // Basic and overflow
    run_table("basic", tbl[0]);
    run_table("ovf", tbl[1]);

    // Backpressure on idx=1 for three cycles; in_data is scrambled meanwhile.
    a_in_valid = 1'b1;
    load_a(tbl[0]);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk_beat("bp0", 10, 0, 10);
    @(negedge clk);
    chk_beat("bp1", 20, 1, 30);
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) a_in_data[i] = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_beat("bp_stall", 20, 1, 30);
      chk("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    chk_beat("bp2", 30, 2, 60);
    @(negedge clk);
    chk_beat("bp3", 40, 3, 100);
    @(negedge clk);
    chk("bp_idle", {31'd0, a_out_valid}, 32'd0);

    // Back-to-back: second vector waits on in_valid and loads with the last beat.
    a_in_valid = 1'b1;
    load_a(tbl[2]);
    @(negedge clk);
    load_a(tbl[3]);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) chk_beat("b2b_v1", tbl[2].v[i], i, tbl[2].s[i]);
      else       chk_beat("b2b_v2", tbl[3].v[i-4], i - 4, tbl[3].s[i-4]);
      if (i == 3) chk("b2b_in_ready", {31'd0, a_in_ready}, 32'd1);
      if (i == 4) a_in_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_idle", {31'd0, a_out_valid}, 32'd0);

    // Reset while idx=2 is on show
    a_in_valid = 1'b1;
    load_a(tbl[0]);
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_beat("rstmid2", 30, 2, 60);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rstmid_in_ready",  {31'd0, a_in_ready},  32'd1);
    rst = 1'b0;
    run_table("after_rst", tbl[4]);

    // N=2, WIDTH=4: {7,9} -> sums 7, 0
    b_in_valid = 1'b1;
    b_in_data[0] = 4'd7;
    b_in_data[1] = 4'd9;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("n2_b0_data", {28'd0, b_out_data}, 32'd7);
    chk("n2_b0_idx",  {31'd0, b_out_idx},  32'd0);
    chk("n2_b0_last", {31'd0, b_out_last}, 32'd0);
    chk("n2_b0_sum",  {28'd0, b_out_sum},  32'd7);
    @(negedge clk);
    chk("n2_b1_data", {28'd0, b_out_data}, 32'd9);
    chk("n2_b1_idx",  {31'd0, b_out_idx},  32'd1);
    chk("n2_b1_last", {31'd0, b_out_last}, 32'd1);
    chk("n2_b1_sum",  {28'd0, b_out_sum},  32'd0);
    @(negedge clk);
    chk("n2_idle", {31'd0, b_out_valid}, 32'd0);

    // N=1: back-to-back single-element vectors, each beat last with sum = data
    c_in_valid = 1'b1;
    c_in_data[0] = 8'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("n1_valid", {31'd0, c_out_valid}, 32'd1);
      chk("n1_data",  {24'd0, c_out_data},  (i == 0) ? 32'd5 : (i == 1) ? 32'd77 : 32'd255);
      chk("n1_last",  {31'd0, c_out_last},  32'd1);
      chk("n1_sum",   {24'd0, c_out_sum},   (i == 0) ? 32'd5 : (i == 1) ? 32'd77 : 32'd255);
      chk("n1_in_ready", {31'd0, c_in_ready}, 32'd1);
      if (i == 0) c_in_data[0] = 8'd77;
      else if (i == 1) c_in_data[0] = 8'd255;
      else c_in_valid = 1'b0;
    end
    @(negedge clk);
    chk("n1_idle", {31'd0, c_out_valid}, 32'd0);

    // Random vectors with random out_ready, checked against prefix sums mod 256
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) begin
        v[i] = int'($urandom_range(0, 255));
        a_in_data[i] = 8'(v[i]);
      end
      chk("rnd_in_ready", {31'd0, a_in_ready}, 32'd1);
      a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) a_in_data[i] = 8'($urandom_range(0, 255));
      k = 0;
      budget = 0;
      while (k < 4 && budget < 200) begin
        run = 0;
        for (int j = 0; j <= k; j++) run += v[j];
        a_out_ready = 1'($urandom_range(0, 1));
        chk_beat("rnd", v[k], k, run % 256);
        if (a_out_ready) k++;
        budget++;
        @(negedge clk);
      end
      if (k < 4) chk("rnd_timeout", 32'(k), 32'd4);
      a_out_ready = 1'b1;
      chk("rnd_idle", {31'd0, a_out_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
